// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Pipeline register between producer stage STAGE and the stage
//               after it. Each rising edge it does exactly one of the
//               following, in priority order:
//                 1. reset  - clear outputs and counters
//                 2. flush  - kill the in-flight instruction (load a bubble)
//                 3. bubble - the producer is stalled but the consumer is not,
//                             so send a NOP downstream
//                 4. load   - capture the upstream instruction
//                 5. hold   - producer and consumer both stalled
//               All outputs come straight from flops. No input reaches an
//               output through combinational logic.
//
// Parameters  : PAY_W   - width of the opaque stage payload
//               STAGE   - producer stage index in the stall vector (1..4)
//               NOP_PAY - payload driven for a bubble and after reset
//
// Ports       : clk        in   1      clock, all state on rising edge
//               rst        in   1      synchronous active-high reset
//               stall      in   6      per-stage stall vector (monotonic)
//               flush      in   1      kill the in-flight instruction
//               in_valid   in   1      upstream holds a real instruction
//               in_pay     in   PAY_W  upstream payload
//               in_wd      in   5      upstream destination register
//               in_wreg    in   1      upstream register-write enable
//               out_valid  out  1      downstream holds a real instruction
//               out_pay    out  PAY_W  registered payload
//               out_wd     out  5      registered destination register
//               out_wreg   out  1      registered write enable (0 if !valid)
//               bubble_cnt out  32     bubbles inserted (saturating)
//               flush_cnt  out  32     flushes that killed something
//
// Build macro : PIPE_STAGE_PERF_CNT_EN
//               Defined     -> bubble_cnt / flush_cnt are live saturating
//                              counters.
//               Not defined -> no counter state, both outputs read 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int               PAY_W   = 128,
    parameter int               STAGE   = 2,
    parameter logic [PAY_W-1:0] NOP_PAY = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [PAY_W-1:0] in_pay,
    input  logic [4:0]       in_wd,
    input  logic             in_wreg,
    output logic             out_valid,
    output logic [PAY_W-1:0] out_pay,
    output logic [4:0]       out_wd,
    output logic             out_wreg,
    output logic [31:0]      bubble_cnt,
    output logic [31:0]      flush_cnt
);

    localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------------
    // Stall decode
    // ------------------------------------------------------------------------
    logic w_stall_self;
    logic w_stall_next;
    logic w_do_bubble;
    logic w_do_load;

    assign w_stall_self = stall[STAGE];
    assign w_stall_next = stall[STAGE+1];

    // Producer stopped while consumer runs: the consumer must not see the
    // same instruction twice, so it gets a NOP. Upstream keeps the real
    // instruction under its own stall, which means nothing is lost.
    assign w_do_bubble = w_stall_self & ~w_stall_next;
    assign w_do_load   = ~w_stall_self;

    // Only two bits of the stall vector matter here. The rest are folded
    // away so the port stays complete for every STAGE value.
    logic w_stall_unused;
    assign w_stall_unused = ^stall;

    // ------------------------------------------------------------------------
    // Payload register
    // ------------------------------------------------------------------------
    logic             r_valid;
    logic [PAY_W-1:0] r_pay;
    logic [4:0]       r_wd;
    logic             r_wreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pay   <= NOP_PAY;
            r_wd    <= 5'd0;
            r_wreg  <= 1'b0;
        end else if (flush || w_do_bubble) begin
            // Clear every field so the bubble leaves no stale state.
            r_valid <= 1'b0;
            r_pay   <= NOP_PAY;
            r_wd    <= 5'd0;
            r_wreg  <= 1'b0;
        end else if (w_do_load) begin
            r_valid <= in_valid;
            r_pay   <= in_pay;
            r_wd    <= in_wd;
            // An invalid slot must never write the register file.
            r_wreg  <= in_wreg & in_valid;
        end
        // Otherwise hold: producer and consumer are both stalled.
    end

    assign out_valid = r_valid;
    assign out_pay   = r_pay;
    assign out_wd    = r_wd;
    assign out_wreg  = r_wreg;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_bubble_evt;
    logic        w_flush_evt;

    // Flush has priority over the bubble, so a flush cycle never counts as a
    // bubble. A flush counts only when it actually killed something, either
    // in this register or at its input.
    assign w_bubble_evt = ~flush & w_do_bubble;
    assign w_flush_evt  = flush & (r_valid | in_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= 32'd0;
            r_flush_cnt  <= 32'd0;
        end else begin
            if (w_bubble_evt && (r_bubble_cnt != C_CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (w_flush_evt && (r_flush_cnt != C_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`else
    assign bubble_cnt = 32'd0;
    assign flush_cnt  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg. It runs directed
//               scenarios followed by randomized traffic. Results are compared
//               against a reference model that tracks the architectural
//               pipeline slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int              PAY_W = 128;
    localparam int              STAGE = 2;
    localparam logic [PAY_W-1:0] NOP  = {4{32'h0BAD_F00D}};
    localparam logic [PAY_W-1:0] A5   = {16{8'hA5}};

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       stall;
    logic             flush;
    logic             in_valid;
    logic [PAY_W-1:0] in_pay;
    logic [4:0]       in_wd;
    logic             in_wreg;
    logic             out_valid;
    logic [PAY_W-1:0] out_pay;
    logic [4:0]       out_wd;
    logic             out_wreg;
    logic [31:0]      bubble_cnt;
    logic [31:0]      flush_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model of the downstream slot.
    logic             m_valid;
    logic [PAY_W-1:0] m_pay;
    logic [4:0]       m_wd;
    logic             m_wreg;
    longint unsigned  m_bc;
    longint unsigned  m_fc;

    pipe_stage_reg #(
        .PAY_W   (PAY_W),
        .STAGE   (STAGE),
        .NOP_PAY (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_pay     (in_pay),
        .in_wd      (in_wd),
        .in_wreg    (in_wreg),
        .out_valid  (out_valid),
        .out_pay    (out_pay),
        .out_wd     (out_wd),
        .out_wreg   (out_wreg),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PAY_W-1:0] obs,
                       input logic [PAY_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, PAY_W'(out_valid), PAY_W'(m_valid));
        chk({tag, ".pay"},   out_pay,           m_pay);
        chk({tag, ".wd"},    PAY_W'(out_wd),    PAY_W'(m_wd));
        chk({tag, ".wreg"},  PAY_W'(out_wreg),  PAY_W'(m_wreg));
`ifdef PIPE_STAGE_PERF_CNT_EN
        chk({tag, ".bcnt"},  PAY_W'(bubble_cnt), PAY_W'(m_bc));
        chk({tag, ".fcnt"},  PAY_W'(flush_cnt),  PAY_W'(m_fc));
`else
        chk({tag, ".bcnt"},  PAY_W'(bubble_cnt), '0);
        chk({tag, ".fcnt"},  PAY_W'(flush_cnt),  '0);
`endif
    endtask

    function automatic longint unsigned sat_inc(input longint unsigned v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    // Predict the slot contents for one edge from the current inputs.
    task automatic model_edge();
        bit producer_stalled = stall[STAGE];
        bit consumer_stalled = stall[STAGE+1];
        if (rst) begin
            m_valid = 0; m_pay = NOP; m_wd = 0; m_wreg = 0;
            m_bc = 0; m_fc = 0;
        end else if (flush) begin
            if (m_valid || in_valid) m_fc = sat_inc(m_fc);
            m_valid = 0; m_pay = NOP; m_wd = 0; m_wreg = 0;
        end else if (producer_stalled && !consumer_stalled) begin
            m_bc = sat_inc(m_bc);
            m_valid = 0; m_pay = NOP; m_wd = 0; m_wreg = 0;
        end else if (!producer_stalled) begin
            m_valid = in_valid; m_pay = in_pay; m_wd = in_wd;
            m_wreg = in_valid && in_wreg;
        end
    endtask

    // Apply inputs, clock one edge, then check away from the edge.
    task automatic step(input string tag, input bit r, input logic [5:0] s,
                        input bit f, input bit v, input logic [PAY_W-1:0] p,
                        input logic [4:0] wd, input bit we);
        rst = r; stall = s; flush = f;
        in_valid = v; in_pay = p; in_wd = wd; in_wreg = we;
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    function automatic logic [PAY_W-1:0] rnd_pay();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        m_valid = 0; m_pay = NOP; m_wd = 0; m_wreg = 0; m_bc = 0; m_fc = 0;
        rst = 1; stall = 0; flush = 0; in_valid = 0; in_pay = 0;
        in_wd = 0; in_wreg = 0;

        // Reset for two cycles, with junk on the other inputs.
        step("rst0", 1, 6'b111111, 1, 1, rnd_pay(), 5'd9, 1);
        step("rst1", 1, 6'b000111, 0, 1, rnd_pay(), 5'd3, 1);

        // First load right after reset.
        step("load_a5", 0, 6'b000000, 0, 1, A5, 5'd5, 1);

        // Three bubble cycles while the producer is stalled.
        for (int i = 0; i < 3; i++)
            step("bubble", 0, 6'b000111, 0, 1, rnd_pay(), 5'd17, 1);

        // Load wd=7, then hold four cycles while the inputs change.
        step("load_wd7", 0, 6'b000000, 0, 1, rnd_pay(), 5'd7, 1);
        for (int i = 0; i < 4; i++)
            step("hold", 0, 6'b001111, 0, $urandom_range(0, 1), rnd_pay(),
                 5'($urandom), 1);

        // Flush together with a bubble stall: the flush takes priority.
        step("flush_stall", 0, 6'b000111, 1, 0, rnd_pay(), 5'd4, 1);

        // Invalid input must not produce a write enable.
        step("inv_wreg", 0, 6'b000000, 0, 0, rnd_pay(), 5'd12, 1);

        // Reset during a hold discards the held instruction.
        step("load_pre", 0, 6'b000000, 0, 1, rnd_pay(), 5'd21, 1);
        step("hold_pre", 0, 6'b111111, 0, 1, rnd_pay(), 5'd22, 1);
        step("rst_hold", 1, 6'b111111, 1, 1, rnd_pay(), 5'd23, 1);
        step("post_rst", 0, 6'b000000, 0, 1, rnd_pay(), 5'd24, 1);

        // Flush of an empty slot with an invalid input: nothing is killed.
        step("bub_empty", 0, 6'b000111, 0, 0, rnd_pay(), 5'd1, 0);
        step("flush_empty", 0, 6'b000000, 1, 0, rnd_pay(), 5'd1, 1);
        // Flush of an empty slot with a valid input: the input is killed.
        step("flush_in", 0, 6'b000000, 1, 1, rnd_pay(), 5'd2, 1);

`ifdef PIPE_STAGE_PERF_CNT_EN
        // Saturation: preload the bubble counter just below its maximum.
        force dut.r_bubble_cnt = 32'hFFFF_FFFD;
        #2;
        release dut.r_bubble_cnt;
        m_bc = 64'hFFFF_FFFD;
        for (int i = 0; i < 4; i++)
            step("bub_sat", 0, 6'b000111, 0, 1, rnd_pay(), 5'd6, 1);
`endif

        // Randomized traffic with a monotonic stall vector.
        for (int i = 0; i < 400; i++) begin
            int          k;
            logic [5:0]  s;
            k = $urandom_range(0, 6);
            s = 6'((7'd1 << k) - 7'd1);
            step("rand", ($urandom_range(0, 39) == 0), s,
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                 rnd_pay(), 5'($urandom), $urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAY_W, default 128, width of the opaque stage payload (aluop/alusel/operands/link/inst packed by the instantiating stage).
REQ-002 Parameter STAGE, default 2, index of this register's producer stage in the stall vector; legal range 1..4.
REQ-003 Parameter NOP_PAY, default all-zero PAY_W-bit value, payload driven for a bubble.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 stall  input  6  per-stage stall vector, bit i=1 stops stage i; monotonic (stall[i]=1 implies stall[j]=1 for j<i).
REQ-007 flush  input  1  kill the in-flight instruction (branch redirect/exception).
REQ-008 in_valid  input  1  upstream holds a real instruction.
REQ-009 in_pay  input  PAY_W  upstream payload.
REQ-010 in_wd  input  5  upstream destination register address.
REQ-011 in_wreg  input  1  upstream register-write enable.
REQ-012 out_valid  output  1  registered: downstream holds a real instruction.
REQ-013 out_pay  output  PAY_W  registered payload.
REQ-014 out_wd  output  5  registered destination address.
REQ-015 out_wreg  output  1  registered write enable, always 0 when out_valid=0.
REQ-016 bubble_cnt  output  32  bubble counter (see Configuration).
REQ-017 flush_cnt  output  32  flush counter (see Configuration).

Function
REQ-018 Per rising edge, exactly one action, evaluated in this priority: reset, flush, bubble, load, hold.
REQ-019 Flush: when flush=1, the register SHALL load a bubble regardless of stall.
REQ-020 Bubble: when stall[STAGE]=1 and stall[STAGE+1]=0, the register SHALL load a bubble.
REQ-021 Bubble content: out_valid=0, out_pay=NOP_PAY, out_wd=0, out_wreg=0; every output field cleared, none left stale.
REQ-022 Load: when stall[STAGE]=0, the register SHALL capture in_valid, in_pay, in_wd, and in_wreg AND in_valid.
REQ-023 Hold: when stall[STAGE]=1 and stall[STAGE+1]=1, all outputs SHALL keep their values.
REQ-024 Latency: one cycle from in_* to out_*; no combinational path from any input to any output.
REQ-025 A bubble loaded while in_valid=1 SHALL NOT be counted as a dropped instruction; upstream retains it under its own stall.
REQ-026 Flush and stall asserted together: flush wins; bubble_cnt not incremented that cycle.

Reset
REQ-027 On rst=1: out_valid=0, out_pay=NOP_PAY, out_wd=0, out_wreg=0, bubble_cnt=0, flush_cnt=0.
REQ-028 rst=1 overrides flush and stall in the same cycle; the first load is possible on the edge after rst deasserts.
REQ-029 Reset mid-hold discards the held instruction.

Configuration
REQ-030 Macro PIPE_STAGE_PERF_CNT_EN. When defined: bubble_cnt increments by 1 on each bubble cycle (REQ-020); flush_cnt increments by 1 on each flush cycle with out_valid=1 or in_valid=1 before the edge; both saturate at 32'hFFFFFFFF and hold there. When not defined: no counter state exists and both outputs are tied to 0.

Verification
REQ-031 rst=1 for 2 cycles, then release with stall=0, in_valid=1, in_pay=0xA5..A5, in_wd=5, in_wreg=1 -> after one edge: out_valid=1, out_pay=0xA5..A5, out_wd=5, out_wreg=1.
REQ-032 With valid output held, stall=6'b000111 (STAGE=2) for 3 cycles -> one bubble per cycle: out_valid=0, out_wreg=0, out_wd=0, out_pay=NOP_PAY; with the macro defined, bubble_cnt=3.
REQ-033 stall=6'b001111 for 4 cycles with out_wd=7 -> outputs unchanged all 4 cycles; bubble_cnt unchanged.
REQ-034 flush=1 with stall=6'b000111 and out_valid=1 -> next cycle out_valid=0; flush_cnt=1; bubble_cnt unchanged.
REQ-035 in_valid=0, in_wreg=1, stall=0 -> out_wreg=0.
REQ-036 With the macro defined, preload bubble_cnt near saturation via force, then 3 bubble cycles -> bubble_cnt=32'hFFFFFFFF. Without the macro -> bubble_cnt=0 and flush_cnt=0 throughout.
